// File: rtl/mc_cpu_core.sv
// Multicycle CPU core: FETCH/DECODE/FETCH2/MEM controller, 4-entry register file, C/Z/N flags,
// and a ready-based handshake to one unified instruction/data memory.
module mc_cpu_core #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RESET_PC = 0,
  localparam int unsigned ADDR_W  = 2 * DATA_W - 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [2:0]        flags_czn,
  output logic [ADDR_W-1:0] dbg_pc,
  input  logic [1:0]        dbg_rsel,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

  localparam logic [3:0] OpMov  = 4'b1000;
  localparam logic [3:0] OpAdd  = 4'b1001;
  localparam logic [3:0] OpAdc  = 4'b1010;
  localparam logic [3:0] OpSub  = 4'b1011;
  localparam logic [3:0] OpAnd  = 4'b1100;
  localparam logic [3:0] OpOr   = 4'b1101;
  localparam logic [3:0] OpNot  = 4'b1110;
  localparam logic [3:0] OpHalt = 4'b1111;

  // Long ops have IR[W-1]=0, so the next two bits select the operation.
  localparam logic [1:0] LopLda = 2'b00;
  localparam logic [1:0] LopSta = 2'b01;
  localparam logic [1:0] LopJmp = 2'b10;
  localparam logic [1:0] LopJz  = 2'b11;

  typedef enum logic [2:0] {StFetch, StDecode, StFetch2, StMem, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tr_q, tr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] rf_q [4];
  logic [DATA_W-1:0] rf_d [4];
  logic              c_q, c_d, z_q, z_d, n_q, n_d;

  logic [3:0]        sop;
  logic [1:0]        lop, rd_sel, rs_sel;
  logic [DATA_W-1:0] rd_val, rs_val, alu_res;
  logic              alu_c;
  logic [DATA_W:0]   sum;
  logic [ADDR_W-1:0] long_addr, pc_inc;

  assign sop       = ir_q[DATA_W-1 -: 4];
  assign lop       = ir_q[DATA_W-2 -: 2];
  assign rd_sel    = ir_q[3:2];
  assign rs_sel    = ir_q[1:0];
  assign rd_val    = rf_q[rd_sel];
  assign rs_val    = rf_q[rs_sel];
  assign long_addr = {mem_rdata, ir_q[DATA_W-4:0]};
  assign pc_inc    = pc_q + ADDR_W'(1);

  // SUB borrow falls out as bit W of the (W+1)-bit difference.
  always_comb begin
    sum     = '0;
    alu_res = rs_val;
    alu_c   = c_q;
    case (sop)
      OpMov: alu_res = rs_val;
      OpAdd: begin
        sum     = {1'b0, rd_val} + {1'b0, rs_val};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OpAdc: begin
        sum     = {1'b0, rd_val} + {1'b0, rs_val} + {{DATA_W{1'b0}}, c_q};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OpSub: begin
        sum     = {1'b0, rd_val} - {1'b0, rs_val};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OpAnd:   alu_res = rd_val & rs_val;
      OpOr:    alu_res = rd_val | rs_val;
      OpNot:   alu_res = ~rs_val;
      default: alu_res = rs_val;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tr_d     = tr_q;
    ir_d     = ir_q;
    rf_d     = rf_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = pc_q;
    unique case (state_q)
      StFetch: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_inc;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!ir_q[DATA_W-1]) begin
          state_d = StFetch2;
        end else if (sop == OpHalt) begin
          state_d = StHalt;
        end else begin
          rf_d[rd_sel] = alu_res;
          c_d          = alu_c;
          z_d          = (alu_res == '0);
          n_d          = alu_res[DATA_W-1];
          state_d      = StFetch;
        end
      end
      StFetch2: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          tr_d    = long_addr;
          pc_d    = pc_inc;
          state_d = StMem;
          if (lop == LopJmp || (lop == LopJz && z_q)) pc_d = long_addr;
          if (lop == LopJmp || lop == LopJz) state_d = StFetch;
        end
      end
      StMem: begin
        mem_addr = tr_q;
        mem_rd   = (lop == LopLda);
        mem_wr   = (lop == LopSta);
        if (mem_ready) begin
          if (lop == LopLda) begin
            rf_d[0] = mem_rdata;
            z_d     = (mem_rdata == '0);
            n_d     = mem_rdata[DATA_W-1];
          end
          state_d = StFetch;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= ResetPc;
      tr_q    <= '0;
      ir_q    <= '0;
      rf_q    <= '{default: '0};
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tr_q    <= tr_d;
      ir_q    <= ir_d;
      rf_q    <= rf_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign mem_wdata = rf_q[0];
  assign halted    = (state_q == StHalt);
  assign flags_czn = {c_q, z_q, n_q};
  assign dbg_pc    = pc_q;
  assign dbg_rdata = rf_q[dbg_rsel];

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: small programs in a behavioural memory, hand-computed
// register, flag, address and latency expectations.
module tb_mc_cpu_core;

  localparam int unsigned DataW = 8;
  localparam int unsigned AddrW = 2 * DataW - 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [AddrW-1:0] mem_addr;
  logic             mem_rd;
  logic             mem_wr;
  logic [DataW-1:0] mem_wdata;
  logic [DataW-1:0] mem_rdata;
  logic             mem_ready;
  logic             halted;
  logic [2:0]       flags_czn;
  logic [AddrW-1:0] dbg_pc;
  logic [1:0]       dbg_rsel;
  logic [DataW-1:0] dbg_rdata;

  logic [7:0] mem [8192];
  int n_checks = 0;
  int n_fail   = 0;

  mc_cpu_core #(
    .DATA_W  (DataW),
    .RESET_PC('h0100)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .halted   (halted),
    .flags_czn(flags_czn),
    .dbg_pc   (dbg_pc),
    .dbg_rsel (dbg_rsel),
    .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr && mem_ready && !rst) mem[mem_addr] = mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    dbg_rsel = idx;
    #1;
    check_eq(tag, {24'h0, dbg_rdata}, {24'h0, exp});
  endtask

  // Bytes are packed first-byte-most-significant in the low n bytes of the vector.
  task automatic load(input int base, input int n, input logic [127:0] bytes);
    for (int i = 0; i < n; i++) mem[13'(base + i)] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic run_until_halt(input int max, output int cyc);
    cyc = 0;
    while (!halted && cyc < max) begin
      tick();
      cyc++;
    end
    check_eq("halt_reached", {31'h0, halted}, 32'd1);
  endtask

  initial begin
    int cyc;
    int acc;
    mem_ready = 1'b1;
    dbg_rsel  = 2'd0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;

    // Reset state
    do_reset(2);
    check_eq("t1_rd", {31'h0, mem_rd}, 32'd1);
    check_eq("t1_wr", {31'h0, mem_wr}, 32'd0);
    check_eq("t1_addr", {19'h0, mem_addr}, 32'h0100);
    check_eq("t1_halted", {31'h0, halted}, 32'd0);
    check_eq("t1_czn", {29'h0, flags_czn}, 32'd0);
    check_eq("t1_pc", {19'h0, dbg_pc}, 32'h0100);

    // ADD with carry: LDA, MOV, LDA, ADD, HALT = 4+2+4+2+2 cycles
    mem['h10] = 8'hF0;
    mem['h11] = 8'h20;
    load('h100, 7, 128'h10_00_84_11_00_94_F0);
    do_reset(2);
    run_until_halt(40, cyc);
    check_eq("t2_cycles", cyc, 32'd14);
    check_reg("t2_r1", 2'd1, 8'h10);
    check_reg("t2_r0", 2'd0, 8'h20);
    check_eq("t2_czn", {29'h0, flags_czn}, 32'b100);
    check_eq("t2_pc", {19'h0, dbg_pc}, 32'h0107);

    // SUB borrow, AND keeps C, ADC uses C, NOT, OR
    load('h100, 11, 128'h10_00_84_11_00_B1_C8_A9_EE_D7_F0);
    do_reset(2);
    repeat (12) tick();
    check_reg("sub_r0", 2'd0, 8'h30);
    check_eq("sub_czn", {29'h0, flags_czn}, 32'b100);
    repeat (2) tick();
    check_reg("and_r2", 2'd2, 8'h00);
    check_eq("and_czn", {29'h0, flags_czn}, 32'b110);
    repeat (2) tick();
    check_reg("adc_r2", 2'd2, 8'hF1);
    check_eq("adc_czn", {29'h0, flags_czn}, 32'b001);
    repeat (2) tick();
    check_reg("not_r3", 2'd3, 8'h0E);
    check_eq("not_czn", {29'h0, flags_czn}, 32'b000);
    repeat (2) tick();
    check_reg("or_r1", 2'd1, 8'hFE);
    check_eq("or_czn", {29'h0, flags_czn}, 32'b001);
    repeat (2) tick();
    check_eq("t2b_halted", {31'h0, halted}, 32'd1);

    // Wait states during FETCH
    load('h100, 2, 128'h84_F0);
    do_reset(2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t3_wait_addr", {19'h0, mem_addr}, 32'h0100);
      check_eq("t3_wait_rd", {31'h0, mem_rd}, 32'd1);
      check_eq("t3_wait_pc", {19'h0, dbg_pc}, 32'h0100);
    end
    mem_ready = 1'b1;
    tick();
    check_eq("t3_decode_rd", {31'h0, mem_rd}, 32'd0);
    check_eq("t3_decode_pc", {19'h0, dbg_pc}, 32'h0101);
    tick();
    check_eq("t3_next_addr", {19'h0, mem_addr}, 32'h0101);

    // JZ taken after SUB R0,R0
    load('h100, 3, 128'hB0_7C_55);
    mem['h0ABC] = 8'hF0;
    do_reset(2);
    repeat (2) tick();
    check_eq("t4_sub_czn", {29'h0, flags_czn}, 32'b010);
    repeat (3) tick();
    check_eq("t4_taken_addr", {19'h0, mem_addr}, 32'h0ABC);
    check_eq("t4_taken_rd", {31'h0, mem_rd}, 32'd1);
    repeat (2) tick();
    check_eq("t4_taken_halt", {31'h0, halted}, 32'd1);

    // JZ not taken after LDA of a non-zero value
    load('h100, 4, 128'h10_00_7C_55);
    do_reset(2);
    repeat (7) tick();
    check_eq("t4_nt_addr", {19'h0, mem_addr}, 32'h0104);
    check_eq("t4_nt_pc", {19'h0, dbg_pc}, 32'h0104);

    // JMP to top of memory, PC wraps to 0
    load('h100, 2, 128'h5F_FF);
    mem['h1FFF] = 8'h84;
    mem['h0000] = 8'hF0;
    do_reset(2);
    repeat (3) tick();
    check_eq("jmp_addr", {19'h0, mem_addr}, 32'h1FFF);
    repeat (2) tick();
    check_eq("wrap_addr", {19'h0, mem_addr}, 32'h0000);
    check_eq("wrap_pc", {19'h0, dbg_pc}, 32'h0000);
    mem['h0000] = 8'h00;

    // STA at 0x1FFF with a wait state, then LDA the same address back
    mem['h12]   = 8'h5A;
    mem['h1FFF] = 8'h00;
    load('h100, 8, 128'h12_00_3F_FF_B0_1F_FF_F0);
    do_reset(2);
    repeat (7) tick();
    check_eq("t5_wr", {31'h0, mem_wr}, 32'd1);
    check_eq("t5_rd", {31'h0, mem_rd}, 32'd0);
    check_eq("t5_addr", {19'h0, mem_addr}, 32'h1FFF);
    check_eq("t5_wdata", {24'h0, mem_wdata}, 32'h5A);
    mem_ready = 1'b0;
    tick();
    check_eq("t5_wait_wr", {31'h0, mem_wr}, 32'd1);
    check_eq("t5_wait_addr", {19'h0, mem_addr}, 32'h1FFF);
    check_eq("t5_wait_pc", {19'h0, dbg_pc}, 32'h0104);
    mem_ready = 1'b1;
    tick();
    check_eq("t5_mem", {24'h0, mem['h1FFF]}, 32'h5A);
    check_eq("t5_next_addr", {19'h0, mem_addr}, 32'h0104);
    run_until_halt(40, cyc);
    check_reg("t5_lda_r0", 2'd0, 8'h5A);
    check_eq("t5_czn", {29'h0, flags_czn}, 32'b000);

    // HALT: no accesses for 20 cycles
    load('h100, 1, 128'hF0);
    do_reset(2);
    repeat (2) tick();
    check_eq("t6_halted", {31'h0, halted}, 32'd1);
    acc = 0;
    repeat (20) begin
      tick();
      if (mem_rd || mem_wr) acc++;
    end
    check_eq("t6_no_access", acc, 32'd0);
    check_eq("t6_still_halted", {31'h0, halted}, 32'd1);
    check_eq("t6_pc", {19'h0, dbg_pc}, 32'h0101);

    // Reset while LDA is waiting for memory
    mem['h10] = 8'h77;
    load('h100, 2, 128'h10_00);
    do_reset(2);
    repeat (3) tick();
    mem_ready = 1'b0;
    repeat (2) tick();
    check_eq("t6_lda_rd", {31'h0, mem_rd}, 32'd1);
    check_eq("t6_lda_addr", {19'h0, mem_addr}, 32'h0010);
    do_reset(1);
    mem_ready = 1'b1;
    check_eq("t6_rst_addr", {19'h0, mem_addr}, 32'h0100);
    check_eq("t6_rst_rd", {31'h0, mem_rd}, 32'd1);
    check_eq("t6_rst_halted", {31'h0, halted}, 32'd0);
    check_reg("t6_rst_r0", 2'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
